// File: rtl/rim_toggler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rim_pkg
// Description : Shared types and constants for the RIM auto-loader. These
//               cover FSM states, panel key codes, the loader base address
//               and the 16-word low-speed RIM loader image.
// Revision    : 1.0 - initial release
// ============================================================================
package rim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KEY_EXTD = 2'd0,
    KEY_ADDR = 2'd1,
    KEY_DEP  = 2'd2,
    KEY_CONT = 2'd3
  } key_t;

  localparam logic [0:11] RIM_BASE  = 12'o7756;
  localparam int          RIM_WORDS = 16;
  localparam int          N_STEPS   = 20;

  // Low-speed RIM loader image, word n lands at RIM_BASE + n.
  function automatic logic [0:11] rim_word(input logic [4:0] n);
    logic [0:11] w;
    case (n)
      5'd0:    w = 12'o6032;
      5'd1:    w = 12'o6031;
      5'd2:    w = 12'o5357;
      5'd3:    w = 12'o6036;
      5'd4:    w = 12'o7106;
      5'd5:    w = 12'o7006;
      5'd6:    w = 12'o7510;
      5'd7:    w = 12'o5357;
      5'd8:    w = 12'o7006;
      5'd9:    w = 12'o6031;
      5'd10:   w = 12'o5367;
      5'd11:   w = 12'o6034;
      5'd12:   w = 12'o7420;
      5'd13:   w = 12'o3776;
      5'd14:   w = 12'o3376;
      5'd15:   w = 12'o5356;
      default: w = 12'o0000;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rim_toggler_rom.sv
`default_nettype none
// ============================================================================
// Module      : rim_rom
// Description : Combinational step table of the auto-loader. It maps a step
//               index to the panel key pressed in that step and the switch
//               register value presented with it.
// Revision    : 1.0 - initial release
// ============================================================================
module rim_rom
  import rim_pkg::*;
(
  input  logic [4:0]  idx,
  output key_t        key,
  output logic [0:11] sr
);

  localparam logic [4:0] DEP_FIRST = 5'd2;
  localparam logic [4:0] DEP_LAST  = 5'(2 + RIM_WORDS - 1);

  // Step decode: EXTD, ADDR, the deposits, ADDR again, then CONT.
  always_comb begin
    key = KEY_DEP;
    sr  = 12'o0000;
    if (idx == 5'd0) begin
      key = KEY_EXTD;
      sr  = 12'o0000;
    end else if (idx == 5'd1 || idx == 5'(N_STEPS - 2)) begin
      key = KEY_ADDR;
      sr  = RIM_BASE;
    end else if (idx == 5'(N_STEPS - 1)) begin
      key = KEY_CONT;
      sr  = RIM_BASE;
    end else if (idx >= DEP_FIRST && idx <= DEP_LAST) begin
      key = KEY_DEP;
      sr  = rim_word(idx - DEP_FIRST);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rim_toggler.sv
`default_nettype none
// ============================================================================
// Module      : rim_toggler
// Description : Front-panel auto-loader for the PDP8e. On start it replays
//               the operator key sequence that toggles in the RIM loader,
//               reloads the start address and optionally presses CONT. When
//               idle it forwards the physical switches with one cycle of
//               latency.
// Revision    : 1.0 - initial release
// ============================================================================
module rim_toggler
  import rim_pkg::*;
#(
  parameter int SETUP_CYCLES = 1000,
  parameter int HOLD_CYCLES  = 2_000_000,
  parameter int GAP_CYCLES   = 2_000_000,
  parameter int AUTO_RUN     = 1,
  parameter int CNT_W        = 22
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:11] sr_in,
  input  logic        extd_addrn_in,
  input  logic        addr_loadn_in,
  input  logic        contn_in,
  input  logic        dep_in,
  output logic [0:11] sr_out,
  output logic        extd_addrn_out,
  output logic        addr_loadn_out,
  output logic        contn_out,
  output logic        dep_out,
  output logic        busy,
  output logic        done
);

  // The timer is loaded with count-1 so a phase of N cycles ends when it reads 0.
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [4:0]       LAST_STEP  = (AUTO_RUN != 0) ? 5'(N_STEPS - 1)
                                                            : 5'(N_STEPS - 2);

  state_t           state, state_nx;
  logic [4:0]       step, step_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             done_nx;
  key_t             rom_key;
  logic [0:11]      rom_sr;
  logic [0:11]      sr_nx;
  logic             extd_nx, addr_nx, cont_nx, dep_nx;

  // The table is indexed with the next step so the output registers line up with the state register.
  rim_rom u_rom (
    .idx (step_nx),
    .key (rom_key),
    .sr  (rom_sr)
  );

  // Next-state, step index and phase timer.
  always_comb begin
    state_nx = state;
    step_nx  = step;
    timer_nx = timer;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_SETUP;
          step_nx  = 5'd0;
          timer_nx = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (timer == '0) begin
          state_nx = ST_PULSE;
          timer_nx = HOLD_LOAD;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      ST_PULSE: begin
        if (timer == '0) begin
          state_nx = ST_GAP;
          timer_nx = GAP_LOAD;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer == '0) begin
          if (step == LAST_STEP) begin
            state_nx = ST_IDLE;
            step_nx  = 5'd0;
            timer_nx = '0;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_SETUP;
            step_nx  = step + 5'd1;
            timer_nx = SETUP_LOAD;
          end
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        step_nx  = 5'd0;
        timer_nx = '0;
      end
    endcase
  end

  // Output values for the coming cycle: pass-through when idle, table-driven otherwise.
  always_comb begin
    sr_nx   = sr_in;
    extd_nx = extd_addrn_in;
    addr_nx = addr_loadn_in;
    cont_nx = contn_in;
    dep_nx  = dep_in;
    if (state_nx != ST_IDLE) begin
      sr_nx   = rom_sr;
      extd_nx = 1'b1;
      addr_nx = 1'b1;
      cont_nx = 1'b1;
      dep_nx  = 1'b0;
      if (state_nx == ST_PULSE) begin
        case (rom_key)
          KEY_EXTD: extd_nx = 1'b0;
          KEY_ADDR: addr_nx = 1'b0;
          KEY_DEP:  dep_nx  = 1'b1;
          KEY_CONT: cont_nx = 1'b0;
          default:  dep_nx  = 1'b0;
        endcase
      end
    end
  end

  // State, timer and registered panel outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      step           <= 5'd0;
      timer          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sr_out         <= 12'o0000;
      extd_addrn_out <= 1'b1;
      addr_loadn_out <= 1'b1;
      contn_out      <= 1'b1;
      dep_out        <= 1'b0;
    end else begin
      state          <= state_nx;
      step           <= step_nx;
      timer          <= timer_nx;
      busy           <= (state_nx != ST_IDLE);
      done           <= done_nx;
      sr_out         <= sr_nx;
      extd_addrn_out <= extd_nx;
      addr_loadn_out <= addr_nx;
      contn_out      <= cont_nx;
      dep_out        <= dep_nx;
    end
  end

  // Zero-length phases and counts that overflow the timer are illegal configurations.
  always @(posedge clk) begin
    assert (SETUP_CYCLES > 0 && HOLD_CYCLES > 0 && GAP_CYCLES > 0)
      else $error("rim_toggler: phase cycle parameters must be at least 1");
    assert (SETUP_CYCLES <= (1 << CNT_W) && HOLD_CYCLES <= (1 << CNT_W) &&
            GAP_CYCLES <= (1 << CNT_W))
      else $error("rim_toggler: CNT_W too narrow for phase cycle parameters");
  end

endmodule
`default_nettype wire
